// File: rtl/line_pkg.sv
// Shared widths, screen limits and state encoding for the line engine.
package line_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;
  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;
  localparam int unsigned ERR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DRAW = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/bresenham_line_engine.sv
// Bresenham line generator: emits one pixel per clock toward the VGA adapter write port.
module bresenham_line_engine
  import line_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y1,
  input  logic [COL_W-1:0] col_in,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  state_t state;

  // Latched endpoints and the walking cursor
  logic [X_W-1:0] xs, xe, cx;
  logic [Y_W-1:0] ys, ye, cy;

  // Bresenham terms
  logic signed [ERR_W-1:0] dx, dy, err;
  logic                    sx_neg, sy_neg;

  logic signed [ERR_W-1:0] dx_raw, dy_raw, dx_abs, dy_abs;
  logic signed [ERR_W-1:0] e2, err_nx;
  logic                    step_x, step_y, at_end, on_screen;
  logic [X_W-1:0]          cx_nx;
  logic [Y_W-1:0]          cy_nx;

  // Setup arithmetic for INIT: signed deltas of zero-extended endpoints and their magnitudes
  always_comb begin
    dx_raw = $signed(ERR_W'(xe)) - $signed(ERR_W'(xs));
    dy_raw = $signed(ERR_W'(ye)) - $signed(ERR_W'(ys));
    dx_abs = dx_raw[ERR_W-1] ? -dx_raw : dx_raw;
    dy_abs = dy_raw[ERR_W-1] ? -dy_raw : dy_raw;
  end

  // Per-pixel step decision; x and y may both advance for a diagonal move
  always_comb begin
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    err_nx = err;
    cx_nx  = cx;
    cy_nx  = cy;
    if (step_x) begin
      err_nx = err_nx + dy;
      cx_nx  = sx_neg ? cx - X_W'(1) : cx + X_W'(1);
    end
    if (step_y) begin
      err_nx = err_nx + dx;
      cy_nx  = sy_neg ? cy - Y_W'(1) : cy + Y_W'(1);
    end
    at_end    = (cx == xe) && (cy == ye);
    on_screen = (cx <= X_W'(X_MAX)) && (cy <= Y_W'(Y_MAX));
  end

  // Control FSM with registered pixel, handshake and colour outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      xs     <= '0;
      ys     <= '0;
      xe     <= '0;
      ye     <= '0;
      cx     <= '0;
      cy     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            xs     <= x0;
            ys     <= y0;
            xe     <= x1;
            ye     <= y1;
            colour <= col_in;
            state  <= ST_INIT;
          end
        end
        ST_INIT: begin
          dx     <= dx_abs;
          dy     <= -dy_abs;
          err    <= dx_abs - dy_abs;
          sx_neg <= !(xs < xe);
          sy_neg <= !(ys < ye);
          cx     <= xs;
          cy     <= ys;
          busy   <= 1'b1;
          state  <= ST_DRAW;
        end
        ST_DRAW: begin
          x    <= cx;
          y    <= cy;
          plot <= on_screen;
          if (at_end) begin
            state <= ST_FIN;
          end else begin
            err <= err_nx;
            cx  <= cx_nx;
            cy  <= cy_nx;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Scoreboard bench for bresenham_line_engine: driver pushes expected pixels, monitor pops and compares.
module tb_bresenham_line_engine;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] col_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  bresenham_line_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .col_in(col_in),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_t exp_q[$];
  int   n_checks = 0, n_pass = 0;
  int   plot_total = 0, done_count = 0, done_cyc = 0, first_plot_cyc = 0, start_cyc = 0;
  bit   in_line = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: integer Bresenham over the whole line, keeping only visible pixels
  task automatic push_line(input int ax0, ay0, ax1, ay1, ac, output int n);
    int dx, dy, sx, sy, err, e2, px, py;
    pix_t p;
    dx = iabs(ax1 - ax0);
    dy = -iabs(ay1 - ay0);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    px = ax0;
    py = ay0;
    forever begin
      if (px <= 159 && py <= 119) begin
        p.x = 8'(px); p.y = 7'(py); p.c = 3'(ac);
        exp_q.push_back(p);
      end
      if (px == ax1 && py == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
    n = ((dx > -dy) ? dx : -dy) + 1;
  endtask

  task automatic set_inputs(input int ax0, ay0, ax1, ay1, ac);
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1); col_in = 3'(ac);
  endtask

  task automatic scramble();
    set_inputs(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)));
  endtask

  task automatic wait_done(input int base, input int limit);
    for (int i = 0; i < limit && done_count == base; i++) @(negedge clk);
    #1;
    chk("done_seen", done_count - base, 1);
  endtask

  // Monitor: every plot pops one expected pixel; done must come with plot and busy low
  always @(negedge clk) begin
    pix_t p;
    if (!reset) begin
      if (plot) begin
        plot_total++;
        if (!in_line) begin
          in_line = 1'b1;
          first_plot_cyc = cyc;
        end
        chk("plot_busy", int'(busy), 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_plot: got x=%0d y=%0d, required no plot", x, y);
        end else begin
          p = exp_q.pop_front();
          chk("pix_x", int'(x), int'(p.x));
          chk("pix_y", int'(y), int'(p.y));
          chk("pix_colour", int'(colour), int'(p.c));
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        in_line = 1'b0;
        chk("done_plot", int'(plot), 0);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  task automatic run_line(input int ax0, ay0, ax1, ay1, ac, input bit mid_pulse);
    int n, base, pt;
    push_line(ax0, ay0, ax1, ay1, ac, n);
    base = done_count;
    @(negedge clk);
    set_inputs(ax0, ay0, ax1, ay1, ac);
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b0;
    scramble();
    if (mid_pulse) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(base, 600);
    chk("first_plot_latency", first_plot_cyc - start_cyc, 2);
    chk("done_latency", done_cyc - start_cyc, n + 2);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    #1 chk("busy_after_done", int'(busy), 0);
    if (mid_pulse) begin
      pt = plot_total;
      repeat (6) @(negedge clk);
      chk("pulse_not_queued", plot_total - pt, 0);
      chk("pulse_busy_low", int'(busy), 0);
    end
  endtask

  initial begin
    int na, nb, base, pt, d1;

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed shapes
    run_line(10, 5, 14, 5, 3, 1'b0);
    run_line(3, 9, 1, 2, 5, 1'b0);
    run_line(7, 7, 7, 7, 6, 1'b0);
    run_line(0, 0, 119, 119, 2, 1'b0);
    pt = plot_total;
    run_line(150, 0, 170, 0, 1, 1'b0);
    chk("offscreen_plot_count", plot_total - pt, 10);
    run_line(20, 100, 60, 10, 4, 1'b1);

    // start held high across two lines; inputs swapped to the second line after acceptance
    push_line(5, 5, 12, 9, 7, na);
    push_line(40, 30, 33, 60, 2, nb);
    base = done_count;
    @(negedge clk);
    set_inputs(5, 5, 12, 9, 7);
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    set_inputs(40, 30, 33, 60, 2);
    wait_done(base, 300);
    d1 = done_cyc;
    chk("held_first_done_latency", d1 - start_cyc, na + 2);
    for (int i = 0; i < 20 && !in_line; i++) @(negedge clk);
    #1;
    chk("held_second_first_plot", first_plot_cyc - d1, 3);
    start = 1'b0;
    wait_done(base + 1, 300);
    chk("held_second_done_latency", done_cyc - d1, nb + 3);
    chk("held_queue_drained", exp_q.size(), 0);

    // Random lines inside the visible area
    for (int k = 0; k < 25; k++)
      run_line(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
               int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
               int'($urandom_range(0, 7)), 1'b0);

    // Reset in the middle of a long line
    push_line(0, 0, 159, 119, 5, na);
    pt = plot_total;
    @(negedge clk);
    set_inputs(0, 0, 159, 119, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && plot_total - pt < 20; i++) begin
      @(negedge clk);
      #1;
    end
    chk("plots_before_reset", plot_total - pt, 20);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    reset = 1'b0;
    exp_q.delete();
    in_line = 1'b0;
    pt = plot_total;
    repeat (40) @(negedge clk);
    chk("no_plots_after_reset", plot_total - pt, 0);
    chk("busy_after_reset", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
